// File: rtl/tone_pkg.sv
// Shared definitions for the tone phase sequencer: default sizes, register
// field selectors, control word bit positions and the waveform type codes
// that wave_lut understands.
package tone_pkg;

   // Default channel count and divider width used by the top-level parameters.
   localparam int DEFAULT_NUM_CH = 4;
   localparam int DEFAULT_DIV_W  = 12;

   // Phase is a 5-bit index into a 32-entry waveform table.
   localparam int PHASE_W = 5;

   // reg_field_in selects which per-channel register a write targets.
   localparam logic REG_FIELD_DIV  = 1'b0;
   localparam logic REG_FIELD_CTRL = 1'b1;

   // Bit positions inside a control write word.
   localparam int CTRL_TYPE_LSB = 0;
   localparam int CTRL_TYPE_MSB = 2;
   localparam int CTRL_EN_BIT   = 3;
   localparam int CTRL_PRST_BIT = 4;

   // Waveform codes passed through to wave_lut. The sequencer advances every
   // type identically; only wave_lut gives them different meanings.
   typedef enum logic [2:0] {
      SQR50    = 3'd0,
      SQR12    = 3'd1,
      SQR25    = 3'd2,
      SQR75    = 3'd3,
      MEM_FULL = 3'd4,
      MEM_LO   = 3'd5,
      MEM_HI   = 3'd6,
      NOISE    = 3'd7
   } waveType_e;

endpackage

// File: rtl/tone_slot_update.sv
// Next-state logic for a single channel slot. The top muxes the serviced
// channel's registers in, and this block decides whether the divider counter
// reloads or counts down and whether the phase advances.
module tone_slot_update
   import tone_pkg::*;
#(
   parameter int DIV_W = DEFAULT_DIV_W
) (
   input  logic [DIV_W-1:0]   cnt,
   input  logic [PHASE_W-1:0] phase,
   input  logic [DIV_W-1:0]   div,
   input  logic               en,
   input  logic               phaseRst,
   output logic [DIV_W-1:0]   nextCnt,
   output logic [PHASE_W-1:0] nextPhase,
   output logic               tick
);

   // A phase reset wins over everything: the phase restarts at zero and the
   // counter restarts a full period without producing a tick. Otherwise an
   // enabled channel with a non-zero divider counts down and, on expiry,
   // reloads and steps its phase. A zero divider means frozen, not fastest.
   always_comb begin
      nextCnt   = cnt;
      nextPhase = phase;
      tick      = 1'b0;
      if (phaseRst) begin
         nextCnt   = div;
         nextPhase = '0;
      end else if (en && (div != '0)) begin
         if (cnt == '0) begin
            nextCnt   = div;
            nextPhase = phase + PHASE_W'(1);
            tick      = 1'b1;
         end else begin
            nextCnt = cnt - DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/tone_phase_seq.sv
// Time-multiplexed phase generator feeding wave_lut. Each clock services one
// channel in round-robin order, advances its phase and presents the phase and
// waveform type one cycle later, tagged with the channel number.
module tone_phase_seq
   import tone_pkg::*;
#(
   parameter  int NUM_CH = DEFAULT_NUM_CH,
   parameter  int DIV_W  = DEFAULT_DIV_W,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic               clk_in,
   input  logic               reset_in,
   input  logic               reg_we_in,
   input  logic [CH_W-1:0]    reg_ch_in,
   input  logic               reg_field_in,
   input  logic [DIV_W-1:0]   reg_data_in,
   output logic [PHASE_W-1:0] lut_addr_out,
   output logic [2:0]         wave_type_out,
   output logic [CH_W-1:0]    ch_out,
   output logic               ch_en_out,
   output logic               tick_out,
   output logic               valid_out
);

   logic [DIV_W-1:0]   divReg   [NUM_CH];
   logic [DIV_W-1:0]   cntReg   [NUM_CH];
   logic [PHASE_W-1:0] phaseReg [NUM_CH];
   waveType_e          typeReg  [NUM_CH];
   logic [NUM_CH-1:0]  enReg;

   logic [CH_W-1:0]    slot;

   logic               isDivWrite;
   logic               isCtrlWrite;
   logic               ctrlPhaseRst;
   logic               servicePhaseRst;

   logic [DIV_W-1:0]   curDiv;
   logic [DIV_W-1:0]   curCnt;
   logic [PHASE_W-1:0] curPhase;
   logic               curEn;
   waveType_e          curType;

   logic [DIV_W-1:0]   nextCnt;
   logic [PHASE_W-1:0] nextPhase;
   logic               nextTick;

   // Decode the register write strobe. A phase reset aimed at the channel
   // being serviced this cycle is handed to the slot update so it can take
   // priority over the normal count/advance; writes to other channels are
   // handled directly in the counter/phase register block.
   always_comb begin
      isDivWrite      = reg_we_in && (reg_field_in == REG_FIELD_DIV);
      isCtrlWrite     = reg_we_in && (reg_field_in == REG_FIELD_CTRL);
      ctrlPhaseRst    = reg_data_in[CTRL_PRST_BIT];
      servicePhaseRst = isCtrlWrite && ctrlPhaseRst && (reg_ch_in == slot);
   end

   // Pick out the serviced channel's registers. These are the values held
   // before any write landing on this edge, so a write that collides with its
   // own channel's slot only affects later slots.
   always_comb begin
      curDiv   = divReg[slot];
      curCnt   = cntReg[slot];
      curPhase = phaseReg[slot];
      curEn    = enReg[slot];
      curType  = typeReg[slot];
   end

   tone_slot_update #(
      .DIV_W(DIV_W)
   ) slotUpdate (
      .cnt      (curCnt),
      .phase    (curPhase),
      .div      (curDiv),
      .en       (curEn),
      .phaseRst (servicePhaseRst),
      .nextCnt  (nextCnt),
      .nextPhase(nextPhase),
      .tick     (nextTick)
   );

   // Round-robin slot pointer. NUM_CH is a power of two so the natural
   // wrap of the counter takes it from NUM_CH-1 back to zero with no stalls.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         slot <= '0;
      end else begin
         slot <= slot + CH_W'(1);
      end
   end

   // Running counter and phase per channel. The serviced channel takes the
   // slot update result; any other channel only changes when a control
   // write with phase reset targets it, which restarts it from its current
   // divider. The phase reset bit itself is never stored.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cntReg[i]   <= '0;
            phaseReg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == slot) begin
               cntReg[i]   <= nextCnt;
               phaseReg[i] <= nextPhase;
            end else if (isCtrlWrite && ctrlPhaseRst && (reg_ch_in == CH_W'(i))) begin
               cntReg[i]   <= divReg[i];
               phaseReg[i] <= '0;
            end
         end
      end
   end

   // Divider registers. A new divider does not disturb a running count; it
   // is only picked up the next time that channel's counter reloads.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         for (int i = 0; i < NUM_CH; i++) begin
            divReg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (isDivWrite && (reg_ch_in == CH_W'(i))) begin
               divReg[i] <= reg_data_in;
            end
         end
      end
   end

   // Control registers: waveform type and enable for each channel.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         enReg <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            typeReg[i] <= SQR50;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (isCtrlWrite && (reg_ch_in == CH_W'(i))) begin
               typeReg[i] <= waveType_e'(reg_data_in[CTRL_TYPE_MSB:CTRL_TYPE_LSB]);
               enReg[i]   <= reg_data_in[CTRL_EN_BIT];
            end
         end
      end
   end

   // Output stage: one cycle after a slot is serviced, present its channel,
   // updated phase, the control values it was serviced with and whether it
   // ticked. Reset clears everything at once so no partial slot escapes.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         lut_addr_out  <= '0;
         wave_type_out <= '0;
         ch_out        <= '0;
         ch_en_out     <= 1'b0;
         tick_out      <= 1'b0;
         valid_out     <= 1'b0;
      end else begin
         lut_addr_out  <= nextPhase;
         wave_type_out <= curType;
         ch_out        <= slot;
         ch_en_out     <= curEn;
         tick_out      <= nextTick;
         valid_out     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tone_phase_seq.sv
// Testbench for tone_phase_seq: directed register writes, a behavioural
// channel model that queues the expected slot outputs, and a monitor that
// compares every valid slot against the queue. Hand-computed checks on
// tick counts and phases cover the named scenarios.
module tb_tone_phase_seq;
   import tone_pkg::*;

   localparam int NUM_CH = 4;
   localparam int DIV_W  = 12;
   localparam int CH_W   = 2;

   logic             clk_in = 1'b0;
   logic             reset_in;
   logic             reg_we_in;
   logic [CH_W-1:0]  reg_ch_in;
   logic             reg_field_in;
   logic [DIV_W-1:0] reg_data_in;
   logic [4:0]       lut_addr_out;
   logic [2:0]       wave_type_out;
   logic [CH_W-1:0]  ch_out;
   logic             ch_en_out;
   logic             tick_out;
   logic             valid_out;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic [4:0]      addr;
      logic [2:0]      wtype;
      logic            en;
      logic            tick;
   } slotOut_t;

   slotOut_t expQ[$];
   slotOut_t monExp;
   slotOut_t monGot;

   int checkCount = 0;
   int errorCount = 0;

   logic [DIV_W-1:0] mDiv   [NUM_CH];
   logic [DIV_W-1:0] mCnt   [NUM_CH];
   logic [4:0]       mPhase [NUM_CH];
   logic [2:0]       mType  [NUM_CH];
   logic             mEn    [NUM_CH];
   int               mSlot;

   int obsPhase    [NUM_CH];
   int obsTicks    [NUM_CH];
   int obsLastTick [NUM_CH];
   int obsEn       [NUM_CH];
   int slots3;
   int tickIdx3[$];

   int found;
   int diffA;
   int diffB;

   tone_phase_seq #(
      .NUM_CH(NUM_CH),
      .DIV_W (DIV_W)
   ) dut (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .reg_we_in    (reg_we_in),
      .reg_ch_in    (reg_ch_in),
      .reg_field_in (reg_field_in),
      .reg_data_in  (reg_data_in),
      .lut_addr_out (lut_addr_out),
      .wave_type_out(wave_type_out),
      .ch_out       (ch_out),
      .ch_en_out    (ch_en_out),
      .tick_out     (tick_out),
      .valid_out    (valid_out)
   );

   // Free-running 10 ns clock.
   always #5 clk_in = ~clk_in;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Build a control write word from its fields.
   function automatic logic [DIV_W-1:0] ctrlWord(input logic en, input logic [2:0] wtype, input logic prst);
      logic [DIV_W-1:0] w;
      w = '0;
      w[2:0] = wtype;
      w[3]   = en;
      w[4]   = prst;
      return w;
   endfunction

   // Return the behavioural model to its post-reset state.
   task automatic modelReset();
      for (int i = 0; i < NUM_CH; i++) begin
         mDiv[i]   = '0;
         mCnt[i]   = '0;
         mPhase[i] = '0;
         mType[i]  = '0;
         mEn[i]    = 1'b0;
      end
      mSlot = 0;
   endtask

   // Forget what the monitor has seen; 99 marks a channel not yet observed.
   task automatic clearObs();
      for (int i = 0; i < NUM_CH; i++) begin
         obsPhase[i]    = 99;
         obsTicks[i]    = 0;
         obsLastTick[i] = 99;
         obsEn[i]       = 99;
      end
      slots3 = 0;
      tickIdx3.delete();
   endtask

   // One clock edge of the behavioural model: service the current slot with
   // the registers as they stand, queue the expected output, then apply the
   // write that lands on the same edge.
   task automatic modelStep(input logic we, input logic [CH_W-1:0] ch, input logic field, input logic [DIV_W-1:0] data);
      slotOut_t e;
      int s;
      logic prst;
      s = mSlot;
      e.ch    = CH_W'(s);
      e.wtype = mType[s];
      e.en    = mEn[s];
      e.tick  = 1'b0;
      prst = we && field && (int'(ch) == s) && data[4];
      if (prst) begin
         mPhase[s] = 5'd0;
         mCnt[s]   = mDiv[s];
      end else if (mEn[s] && (mDiv[s] != 0)) begin
         if (mCnt[s] == 0) begin
            mCnt[s]   = mDiv[s];
            mPhase[s] = mPhase[s] + 5'd1;
            e.tick    = 1'b1;
         end else begin
            mCnt[s] = mCnt[s] - 1;
         end
      end
      e.addr = mPhase[s];
      expQ.push_back(e);
      if (we) begin
         if (!field) begin
            mDiv[ch] = data;
         end else begin
            mType[ch] = data[2:0];
            mEn[ch]   = data[3];
            if (data[4] && (int'(ch) != s)) begin
               mPhase[ch] = 5'd0;
               mCnt[ch]   = mDiv[ch];
            end
         end
      end
      mSlot = (s + 1) % NUM_CH;
   endtask

   // Drive one cycle of inputs, predict its slot, and return just after the
   // monitor has looked at the resulting output.
   task automatic applyStimulus(input logic we, input logic [CH_W-1:0] ch, input logic field, input logic [DIV_W-1:0] data);
      reg_we_in    = we;
      reg_ch_in    = ch;
      reg_field_in = field;
      reg_data_in  = data;
      modelStep(we, ch, field, data);
      @(negedge clk_in);
      #1;
      reg_we_in = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, '0, 1'b0, '0);
      end
   endtask

   task automatic writeReg(input logic [CH_W-1:0] ch, input logic field, input logic [DIV_W-1:0] data);
      applyStimulus(1'b1, ch, field, data);
   endtask

   // Idle until the next edge will service channel target.
   task automatic waitSlot(input int target);
      for (int i = 0; i < NUM_CH && mSlot != target; i++) begin
         idle(1);
      end
   endtask

   // Monitor: every valid slot must match the oldest queued expectation; a
   // valid with nothing queued, or a queued slot with no valid, is an error.
   // Observed values feed the hand-computed scenario checks.
   always @(negedge clk_in) begin
      if (!reset_in) begin
         if (valid_out) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_valid", 32'(valid_out), 32'd0);
            end else begin
               monExp = expQ.pop_front();
               monGot = {ch_out, lut_addr_out, wave_type_out, ch_en_out, tick_out};
               checkOutput($sformatf("slot_ch%0d", monExp.ch), 32'(monGot), 32'(monExp));
               obsPhase[ch_out]    = int'(lut_addr_out);
               obsLastTick[ch_out] = int'(tick_out);
               obsEn[ch_out]       = int'(ch_en_out);
               if (tick_out) obsTicks[ch_out]++;
               if (ch_out == 2'd3) begin
                  slots3++;
                  if (tick_out) tickIdx3.push_back(slots3);
               end
            end
         end else if (expQ.size() != 0) begin
            checkOutput("missing_valid", 32'(valid_out), 32'd1);
            void'(expQ.pop_front());
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence.
   initial begin
      reset_in     = 1'b1;
      reg_we_in    = 1'b0;
      reg_ch_in    = '0;
      reg_field_in = 1'b0;
      reg_data_in  = '0;
      modelReset();
      clearObs();
      repeat (2) @(negedge clk_in);
      #1;
      checkOutput("reset_outputs", 32'({lut_addr_out, wave_type_out, ch_out, ch_en_out, tick_out, valid_out}), 32'd0);
      reset_in = 1'b0;
      #1;
      checkOutput("valid_before_first_edge", 32'(valid_out), 32'd0);

      // Idle after reset: all channels disabled, phase 0, no ticks.
      idle(8);
      checkOutput("t1_ticks", 32'(obsTicks[0] + obsTicks[1] + obsTicks[2] + obsTicks[3]), 32'd0);
      checkOutput("t1_ch3_phase", 32'(obsPhase[3]), 32'd0);
      checkOutput("t1_ch0_en", 32'(obsEn[0]), 32'd0);

      // ch1 div=1: tick every second ch1 slot, phase wraps after 64 slots.
      waitSlot(2);
      writeReg(2'd1, REG_FIELD_DIV, 12'd1);
      writeReg(2'd1, REG_FIELD_CTRL, ctrlWord(1'b1, SQR50, 1'b0));
      obsTicks[1] = 0;
      idle(128);
      checkOutput("t2_ch1_phase_half", 32'(obsPhase[1]), 32'd16);
      idle(128);
      checkOutput("t2_ch1_ticks", 32'(obsTicks[1]), 32'd32);
      checkOutput("t2_ch1_phase_wrap", 32'(obsPhase[1]), 32'd0);

      // ch2 enabled with div=0 stays frozen; then div=3 ticks every 4th slot.
      waitSlot(3);
      writeReg(2'd2, REG_FIELD_CTRL, ctrlWord(1'b1, SQR25, 1'b0));
      obsTicks[2] = 0;
      idle(400);
      checkOutput("t3_frozen_ticks", 32'(obsTicks[2]), 32'd0);
      checkOutput("t3_frozen_phase", 32'(obsPhase[2]), 32'd0);
      checkOutput("t3_frozen_en", 32'(obsEn[2]), 32'd1);
      waitSlot(0);
      writeReg(2'd2, REG_FIELD_DIV, 12'd3);
      obsTicks[2] = 0;
      idle(64);
      checkOutput("t3_div3_ticks", 32'(obsTicks[2]), 32'd4);
      checkOutput("t3_div3_phase", 32'(obsPhase[2]), 32'd4);

      // ch0 div=2 up to phase 9, then a phase reset in its own slot.
      waitSlot(1);
      writeReg(2'd0, REG_FIELD_DIV, 12'd2);
      writeReg(2'd0, REG_FIELD_CTRL, ctrlWord(1'b1, SQR12, 1'b0));
      found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         idle(1);
         if (obsPhase[0] == 9) found = 1;
      end
      checkOutput("t4_reach_phase9", 32'(found), 32'd1);
      waitSlot(0);
      writeReg(2'd0, REG_FIELD_CTRL, ctrlWord(1'b1, SQR12, 1'b1));
      checkOutput("t4_collision_phase", 32'(obsPhase[0]), 32'd0);
      checkOutput("t4_collision_tick", 32'(obsLastTick[0]), 32'd0);
      obsTicks[0] = 0;
      idle(8);
      checkOutput("t4_no_early_tick", 32'(obsTicks[0]), 32'd0);
      idle(4);
      checkOutput("t4_tick_after_reload", 32'(obsTicks[0]), 32'd1);
      checkOutput("t4_phase_after_reload", 32'(obsPhase[0]), 32'd1);

      // ch3 noise, div=5 changed to 2 mid-count: periods 6 then 3.
      waitSlot(0);
      writeReg(2'd3, REG_FIELD_DIV, 12'd5);
      writeReg(2'd3, REG_FIELD_CTRL, ctrlWord(1'b1, NOISE, 1'b0));
      slots3 = 0;
      tickIdx3.delete();
      idle(2);
      idle(8);
      writeReg(2'd3, REG_FIELD_DIV, 12'd2);
      idle(32);
      checkOutput("t5_tick_count", 32'(tickIdx3.size()), 32'd3);
      diffA = -1;
      diffB = -1;
      if (tickIdx3.size() >= 3) begin
         diffA = tickIdx3[1] - tickIdx3[0];
         diffB = tickIdx3[2] - tickIdx3[1];
      end
      checkOutput("t5_old_period", 32'(diffA), 32'd6);
      checkOutput("t5_new_period", 32'(diffB), 32'd3);

      // Run ch3 to phase 17, then assert reset between clock edges.
      found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         idle(1);
         if (obsPhase[3] == 17) found = 1;
      end
      checkOutput("t6_reach_phase17", 32'(found), 32'd1);
      #2;
      reset_in = 1'b1;
      #1;
      checkOutput("t6_async_clear", 32'({lut_addr_out, wave_type_out, ch_out, ch_en_out, tick_out, valid_out}), 32'd0);
      expQ.delete();
      modelReset();
      clearObs();
      @(posedge clk_in);
      @(negedge clk_in);
      #1;
      checkOutput("t6_held_in_reset", 32'({lut_addr_out, wave_type_out, ch_out, ch_en_out, tick_out, valid_out}), 32'd0);
      reset_in = 1'b0;
      idle(8);
      checkOutput("t6_ch3_phase", 32'(obsPhase[3]), 32'd0);
      checkOutput("t6_ch3_en", 32'(obsEn[3]), 32'd0);
      checkOutput("t6_queue_drained", 32'(expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
